serial_tx_framer: RTL and testbench
===================================

Name: serial_tx_framer

Overview:
- Parallel-to-serial framing transmitter: accepts a DATA_WIDTH word on a valid/ready handshake and shifts it onto a single-bit line.
- Frame order: start bit, data LSB first, optional parity bit, stop bit.
- Produces the 1-bit `in` stream consumed by the single-bit combinational and sequential blocks in the basic-code library, replacing hand-written testbench stimulus. Fully synchronous to one clock.

Parameters:
- DATA_WIDTH, 8, data bits per frame; must be >= 1.
- BIT_CYCLES, 4, clk cycles each serial bit is held; must be >= 1 (1 = one bit per clock).

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  reset, asynchronous, active-low.
- data_in  input  DATA_WIDTH  word to transmit; sampled only on handshake.
- valid_in  input  1  data_in valid request.
- ready_out  output  1  block can accept a word this cycle.
- out  output  1  serial line, registered; idle level 1.
- busy  output  1  frame in progress (any state other than IDLE).

Behaviour:
- Reset (rst low, asynchronous):
  - state = IDLE, out = 1, busy = 0, ready_out = 0, shift register and counters cleared.
  - Reset asserted mid-frame aborts the frame immediately; the line returns to 1 with no partial stop bit.
  - The aborted word is discarded, not resumed.
- ready_out after reset: goes 1 on the first clk edge after rst is released.
- States: IDLE, START, DATA, PARITY (only with the optional feature), STOP.
- Handshake:
  - Accept occurs on a rising edge with valid_in = 1 and ready_out = 1.
  - data_in is latched at accept; later changes to data_in are ignored.
  - valid_in while ready_out = 0 is ignored; there is no queueing.
- ready_out = 1 in IDLE, and in the final clk cycle of STOP; 0 otherwise.
- IDLE:
  - out = 1.
  - On accept -> START; out = 0 and busy = 1 from the next cycle (latency 1 clk from accept to start-bit edge).
- Bit timing:
  - Every bit (start, data, parity, stop) is held for exactly BIT_CYCLES clk cycles.
  - A bit counter of width max(1, $clog2(BIT_CYCLES)) counts 0..BIT_CYCLES-1, then wraps.
- START: out = 0 for BIT_CYCLES -> DATA.
- DATA:
  - out = shift register bit 0; the register shifts right at each bit boundary.
  - After DATA_WIDTH bits -> PARITY if enabled, else STOP.
  - The data index counter wraps to 0 at exit.
- STOP: out = 1 for BIT_CYCLES cycles. In the final stop cycle:
  - Accept -> START next cycle (back-to-back frames, no idle gap; busy stays 1).
  - No accept -> IDLE; busy = 0 next cycle.
- Frame length: (2 + DATA_WIDTH + P) * BIT_CYCLES clk cycles, where P = 1 with parity and 0 without.
- Simultaneous events:
  - Accept in the last STOP cycle and in IDLE behave identically.
  - valid_in held high continuously yields continuous frames.
- BIT_CYCLES = 1: ready_out in STOP is 1 for the single stop cycle.

Optional Feature:
- Macro: SERIAL_TX_PARITY_EN.
- Defined:
  - PARITY state is inserted between DATA and STOP.
  - out = even parity (XOR of the latched data bits) for BIT_CYCLES cycles.
  - Frame is BIT_CYCLES longer.
- Undefined:
  - No PARITY state and no parity logic; DATA goes directly to STOP.

Test Plan:
- Reset behaviour:
  - Stimulus: rst low at t=0; release at the 15 ns edge region.
  - Required: out = 1, busy = 0, ready_out = 0 during reset; ready_out = 1 one clk after release.
- Single frame, defaults, no parity:
  - Stimulus: send 0xA5.
  - Required: out bits 0,1,0,1,0,0,1,0,1,1, each held 4 clks; 40 clks total; busy = 0 afterwards.
- Parity on:
  - Stimulus: SERIAL_TX_PARITY_EN defined; send 0xA5, then 0x07.
  - Required: 0xA5 gives parity bit 0; 0x07 gives parity bit 1; 44 clks per frame.
- Back-to-back:
  - Stimulus: valid_in held high with 0x3C then 0xFF.
  - Required: the start bit of 0xFF directly follows the 4-clk stop bit of 0x3C; ready_out pulses for exactly 1 clk in each STOP; busy never drops between frames.
- Ignored requests:
  - Stimulus: pulse valid_in with 0x11 during the DATA state of a frame carrying 0x5A.
  - Required: the 0x5A frame is unchanged; 0x11 is never transmitted.
- Reset mid-frame, then recovery:
  - Stimulus: assert rst during data bit 3 of 0xC3.
  - Required: out = 1 immediately, without waiting for clk.
  - After release, send 0x81: a clean full frame of 0x81.

Source files
------------

// File: rtl/serial_tx_framer.sv
// Parallel-to-serial framer: start bit, data LSB first, optional even parity, stop bit.
// Define SERIAL_TX_PARITY_EN to insert the parity bit between data and stop.
module serial_tx_framer #(
  parameter int DATA_WIDTH = 8,
  parameter int BIT_CYCLES = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic                  valid_in,
  output logic                  ready_out,
  output logic                  out,
  output logic                  busy
);

  localparam int CW = (BIT_CYCLES > 1) ? $clog2(BIT_CYCLES) : 1;
  localparam int IW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [CW-1:0] LAST_CNT   = CW'(BIT_CYCLES - 1);
  localparam logic [IW-1:0] LAST_IDX   = IW'(DATA_WIDTH - 1);
  localparam logic          STOP_READY = (BIT_CYCLES == 1);

`ifdef SERIAL_TX_PARITY_EN
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
`endif

  state_t                  state;
  logic [CW-1:0]           bit_cnt;
  logic [IW-1:0]           idx;
  logic [DATA_WIDTH-1:0]   shreg;
  logic [DATA_WIDTH-1:0]   sh_next;
  logic                    last_bit;
  logic                    accept;
`ifdef SERIAL_TX_PARITY_EN
  logic                    par;
`endif

  assign accept   = valid_in & ready_out;
  assign last_bit = (bit_cnt == LAST_CNT);
  assign sh_next  = shreg >> 1;

  // ready_out is only ever high in IDLE or the last STOP cycle, so accept alone marks a load
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      out       <= 1'b1;
      busy      <= 1'b0;
      ready_out <= 1'b0;
      bit_cnt   <= '0;
      idx       <= '0;
      shreg     <= '0;
`ifdef SERIAL_TX_PARITY_EN
      par       <= 1'b0;
`endif
    end else if (accept) begin
      state     <= START;
      out       <= 1'b0;
      busy      <= 1'b1;
      ready_out <= 1'b0;
      bit_cnt   <= '0;
      idx       <= '0;
      shreg     <= data_in;
`ifdef SERIAL_TX_PARITY_EN
      par       <= ^data_in;
`endif
    end else begin
      case (state)
        IDLE: begin
          out       <= 1'b1;
          busy      <= 1'b0;
          ready_out <= 1'b1;
          bit_cnt   <= '0;
        end
        START: begin
          if (last_bit) begin
            state   <= DATA;
            bit_cnt <= '0;
            out     <= shreg[0];
          end else begin
            bit_cnt <= bit_cnt + CW'(1);
          end
        end
        DATA: begin
          if (last_bit) begin
            bit_cnt <= '0;
            if (idx == LAST_IDX) begin
              idx <= '0;
`ifdef SERIAL_TX_PARITY_EN
              state <= PARITY;
              out   <= par;
`else
              state     <= STOP;
              out       <= 1'b1;
              ready_out <= STOP_READY;
`endif
            end else begin
              idx   <= idx + IW'(1);
              shreg <= sh_next;
              out   <= sh_next[0];
            end
          end else begin
            bit_cnt <= bit_cnt + CW'(1);
          end
        end
`ifdef SERIAL_TX_PARITY_EN
        PARITY: begin
          if (last_bit) begin
            state     <= STOP;
            bit_cnt   <= '0;
            out       <= 1'b1;
            ready_out <= STOP_READY;
          end else begin
            bit_cnt <= bit_cnt + CW'(1);
          end
        end
`endif
        STOP: begin
          // Raise ready one cycle ahead so it is visible during the final stop cycle
          if (last_bit) begin
            state     <= IDLE;
            bit_cnt   <= '0;
            out       <= 1'b1;
            busy      <= 1'b0;
            ready_out <= 1'b1;
          end else begin
            bit_cnt   <= bit_cnt + CW'(1);
            ready_out <= ((bit_cnt + CW'(1)) == LAST_CNT);
          end
        end
        default: begin
          state     <= IDLE;
          out       <= 1'b1;
          busy      <= 1'b0;
          ready_out <= 1'b0;
          bit_cnt   <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_tx_framer.sv
// Directed bench for serial_tx_framer with default parameters (DATA_WIDTH=8, BIT_CYCLES=4).
// Expected frames follow SERIAL_TX_PARITY_EN when the macro is defined.
module tb_serial_tx_framer;

`ifdef SERIAL_TX_PARITY_EN
  localparam int NB = 11;
`else
  localparam int NB = 10;
`endif
  localparam int BC = 4;

  logic       clk;
  logic       rst;
  logic [7:0] data_in;
  logic       valid_in;
  logic       ready_out;
  logic       out;
  logic       busy;

  int checks = 0;
  int errors = 0;

  serial_tx_framer #(.DATA_WIDTH(8), .BIT_CYCLES(BC)) dut (
    .clk       (clk),
    .rst       (rst),
    .data_in   (data_in),
    .valid_in  (valid_in),
    .ready_out (ready_out),
    .out       (out),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [7:0]  data;
    logic [10:0] exp;   // line value per bit, transmit order from bit 0
    logic        chain; // keep valid high and send the next entry back-to-back
    int          inj;   // frame cycle to pulse a stray request, -1 for none
  } vec_t;

  localparam int NV = 6;
  vec_t vecs [NV];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic start_frame(input logic [7:0] d);
    int n = 0;
    while (!ready_out && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("ready_before_send", {31'd0, ready_out}, 32'd1);
    valid_in = 1'b1;
    data_in  = d;
    @(negedge clk);
  endtask

  task automatic play_frame(input string tag, input logic [10:0] exp, input logic hold,
                            input logic [7:0] nxt, input int inj);
    for (int k = 0; k < NB * BC; k++) begin
      chk($sformatf("%s_out_c%0d", tag, k), {31'd0, out}, {31'd0, exp[k / BC]});
      chk($sformatf("%s_busy_c%0d", tag, k), {31'd0, busy}, 32'd1);
      chk($sformatf("%s_ready_c%0d", tag, k), {31'd0, ready_out},
          (k == NB * BC - 1) ? 32'd1 : 32'd0);
      if (k == 0) begin
        valid_in = hold;
        data_in  = nxt;
      end
      if (k == inj) begin
        valid_in = 1'b1;
        data_in  = 8'h11;
      end else if (k == inj + 1) begin
        valid_in = hold;
      end
      @(negedge clk);
    end
    if (!hold) begin
      chk({tag, "_idle_out"}, {31'd0, out}, 32'd1);
      chk({tag, "_idle_busy"}, {31'd0, busy}, 32'd0);
      chk({tag, "_idle_ready"}, {31'd0, ready_out}, 32'd1);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [7:0]  nxt;
    logic [10:0] exp81;
`ifdef SERIAL_TX_PARITY_EN
    vecs[0] = '{8'hA5, 11'h54A, 1'b0, -1};
    vecs[1] = '{8'h07, 11'h60E, 1'b0, -1};
    vecs[2] = '{8'h3C, 11'h478, 1'b1, -1};
    vecs[3] = '{8'hFF, 11'h5FE, 1'b0, -1};
    vecs[4] = '{8'h5A, 11'h4B4, 1'b0, 12};
    vecs[5] = '{8'h00, 11'h400, 1'b0, -1};
    exp81   = 11'h502;
`else
    vecs[0] = '{8'hA5, 11'h34A, 1'b0, -1};
    vecs[1] = '{8'h07, 11'h20E, 1'b0, -1};
    vecs[2] = '{8'h3C, 11'h278, 1'b1, -1};
    vecs[3] = '{8'hFF, 11'h3FE, 1'b0, -1};
    vecs[4] = '{8'h5A, 11'h2B4, 1'b0, 12};
    vecs[5] = '{8'h00, 11'h200, 1'b0, -1};
    exp81   = 11'h302;
`endif

    rst      = 1'b0;
    valid_in = 1'b0;
    data_in  = 8'h00;

    // Reset state, then release just before the 15 ns edge
    @(negedge clk);
    chk("rst_out", {31'd0, out}, 32'd1);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_ready", {31'd0, ready_out}, 32'd0);
    #2 rst = 1'b1;
    @(negedge clk);
    chk("post_rst_ready", {31'd0, ready_out}, 32'd1);
    chk("post_rst_busy", {31'd0, busy}, 32'd0);
    chk("post_rst_out", {31'd0, out}, 32'd1);

    for (int i = 0; i < NV; i++) begin
      if (i == 0 || !vecs[i - 1].chain) start_frame(vecs[i].data);
      if (vecs[i].chain && i + 1 < NV) nxt = vecs[i + 1].data;
      else                            nxt = ~vecs[i].data;
      play_frame($sformatf("v%0d", i), vecs[i].exp, vecs[i].chain, nxt, vecs[i].inj);
    end

    // Abort 0xC3 during data bit 3 (frame bit 4), with no clock edge involved
    start_frame(8'hC3);
    valid_in = 1'b0;
    for (int k = 0; k < 18; k++) begin
      chk($sformatf("abort_out_c%0d", k), {31'd0, out},
          {31'd0, ((k / BC) == 0) ? 1'b0 : 8'hC3 >> ((k / BC) - 1)} & 32'd1);
      @(negedge clk);
    end
    chk("abort_bit3_low", {31'd0, out}, 32'd0);
    #2 rst = 1'b0;
    #1;
    chk("abort_out_async", {31'd0, out}, 32'd1);
    chk("abort_busy_async", {31'd0, busy}, 32'd0);
    chk("abort_ready_async", {31'd0, ready_out}, 32'd0);
    @(negedge clk);
    chk("abort_hold_out", {31'd0, out}, 32'd1);
    #2 rst = 1'b1;
    @(negedge clk);
    chk("recover_ready", {31'd0, ready_out}, 32'd1);
    chk("recover_busy", {31'd0, busy}, 32'd0);
    start_frame(8'h81);
    play_frame("recover81", exp81, 1'b0, 8'h7E, -1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
